eth_pll_lock_supervisor: RTL and testbench
==========================================

Name: eth_pll_lock_supervisor

Overview:
- Control-side counterpart of the Ethernet fabric PLL wrapper.
- Drives the PLL reset, consumes its asynchronous `locked` output, and qualifies lock before releasing the downstream datapath reset.
- Runs on the 156.25 MHz reference clock, which is valid before the PLL locks.
- Handles lock timeouts with bounded retries, loss-of-lock recovery, software-forced relock, and a sticky fault.

Parameters:
- RST_CYCLES, 16: cycles that pll_rst is held per reset pulse.
- LOCK_TIMEOUT, 4096: cycles in WAIT_LOCK before a lock attempt is declared failed.
- STABLE_CYCLES, 256: consecutive synchronized-locked cycles required before READY.
- MAX_RETRIES, 3: failed lock attempts tolerated before FAULT.
- LOSS_W, 8: width of the saturating lock-loss counter.

Ports:
- refclk  in  1  reference clock; sole clock of the block.
- rst  in  1  reset; synchronous to refclk, active-high.
- pll_locked  in  1  PLL lock indicator; asynchronous to refclk.
- force_relock  in  1  single-cycle request to re-run the lock sequence.
- pll_rst  out  1  reset to the PLL.
- sys_rst  out  1  reset to the 312.5 MHz datapath; downstream re-synchronizes it.
- ready  out  1  PLL locked and qualified.
- fault  out  1  sticky: retries exhausted.
- lock_loss_cnt  out  LOSS_W  count of lock losses while READY; saturating.
- state_dbg  out  3  current FSM state encoding.

Behaviour:
- All outputs are registered.
- Reset values (rst=1):
  - state=RESET_PLL, pll_rst=1, sys_rst=1.
  - ready=0, fault=0, lock_loss_cnt=0.
  - Internal timer=0, retry count=0.
- rst dominates every other input in every state.
- pll_locked passes through a 2-flop synchronizer to give locked_s. Latency from pll_locked to FSM decision is 2 cycles.
- RESET_PLL:
  - pll_rst=1, sys_rst=1, ready=0.
  - Timer counts 0..RST_CYCLES-1, then goes to WAIT_LOCK with the timer cleared.
  - pll_rst is high for exactly RST_CYCLES cycles.
- WAIT_LOCK:
  - pll_rst=0; the timer increments.
  - If locked_s=1, go to STABILIZE with the timer cleared.
  - If the timer reaches LOCK_TIMEOUT-1 with locked_s=0, increment retries. If retries then equals MAX_RETRIES, go to FAULT; otherwise go to RESET_PLL.
- STABILIZE:
  - If locked_s=0, return to WAIT_LOCK with the timer cleared. Retries are unchanged.
  - If locked_s=1 for STABLE_CYCLES consecutive cycles, go to READY and clear retries.
- READY:
  - sys_rst=0, ready=1; both take effect on the first cycle in READY.
  - If locked_s=0, go to RESET_PLL and increment lock_loss_cnt. The counter saturates at 2^LOSS_W-1.
  - sys_rst=1 and ready=0 take effect the cycle after locked_s is sampled low.
- FAULT:
  - pll_rst=1, sys_rst=1, ready=0, fault=1.
  - Left only via rst, or via force_relock, which clears fault and retries and goes to RESET_PLL.
- force_relock:
  - In WAIT_LOCK, STABILIZE or READY: go to RESET_PLL and clear retries.
  - A forced relock alone does not count as a loss.
  - In RESET_PLL: restart the timer from 0.
- Simultaneous lock loss and force_relock in READY: go to RESET_PLL once and do count the loss.
- A pll_locked glitch shorter than 1 refclk cycle may be missed; this is acceptable.
- Timer width is clog2 of the maximum of RST_CYCLES, LOCK_TIMEOUT and STABLE_CYCLES. The timer never wraps because every state clears it on exit.
- state_dbg encodes the current state:
  - RESET_PLL=0, WAIT_LOCK=1, STABILIZE=2, READY=3, FAULT=4.

Decomposition:
- Package eth_pll_sup_pkg holds:
  - the state enum typedef with the fixed encodings above;
  - a clog2-based timer width function.
- One sub-module: eth_sync_2ff, a generic 2-flop bit synchronizer, reusable for other async status lines.
- The FSM, timer and counters stay in the top module.

Test Plan:
All scenarios use RST_CYCLES=4, LOCK_TIMEOUT=32, STABLE_CYCLES=8, MAX_RETRIES=2, LOSS_W=8.
- Normal bring-up: release rst, raise pll_locked 10 cycles later -> pll_rst high exactly 4 cycles; ready=1 and sys_rst=0 at 2+8 cycles after the pll_locked rise (±1 for synchronizer phase); lock_loss_cnt=0.
- Timeout/fault: hold pll_locked=0 -> two 4-cycle pll_rst pulses separated by 32 cycles; fault=1 and state_dbg=4 after the second timeout; pll_rst stays 1; force_relock then clears fault and restarts the sequence.
- Stabilize bounce: locked high 5 cycles, low 1, high again -> returns to WAIT_LOCK; ready=1 only after 8 uninterrupted locked_s cycles; retries not incremented.
- Loss of lock in READY: drop pll_locked -> sys_rst=1 and ready=0 within 3 cycles; lock_loss_cnt=1; new 4-cycle pll_rst pulse. Repeat 300 times -> lock_loss_cnt saturates at 255.
- Collision: force_relock and pll_locked fall in the same cycle in READY -> single RESET_PLL entry; lock_loss_cnt increments by 1. force_relock alone -> no increment.
- Mid-operation reset: assert rst during STABILIZE and during FAULT -> next cycle shows all reset values (pll_rst=1, fault=0, lock_loss_cnt=0).

Source files
------------

// File: rtl/eth_pll_sup_pkg.sv
// Shared types and helpers for the Ethernet PLL lock supervisor.
// State encodings are visible on state_dbg, so they stay fixed.
package eth_pll_sup_pkg;

  typedef enum logic [2:0] {
    RESET_PLL = 3'd0,
    WAIT_LOCK = 3'd1,
    STABILIZE = 3'd2,
    READY     = 3'd3,
    FAULT     = 3'd4
  } sup_state_e;

  function automatic int timer_w(
    input int a,
    input int b,
    input int c
  );
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/eth_sync_2ff.sv
// Generic two-flop bit synchronizer for asynchronous status lines.
// Reset clears both stages so the output starts deasserted.
module eth_sync_2ff (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/eth_pll_lock_supervisor.sv
// Drives the fabric PLL reset, qualifies its lock and gates the
// datapath reset; handles timeouts, lock loss and forced relock.
module eth_pll_lock_supervisor
  import eth_pll_sup_pkg::*;
#(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 4096,
  parameter int STABLE_CYCLES = 256,
  parameter int MAX_RETRIES   = 3,
  parameter int LOSS_W        = 8
) (
  input  logic              refclk,
  input  logic              rst,
  input  logic              pll_locked,
  input  logic              force_relock,
  output logic              pll_rst,
  output logic              sys_rst,
  output logic              ready,
  output logic              fault,
  output logic [LOSS_W-1:0] lock_loss_cnt,
  output logic [2:0]        state_dbg
);

  localparam int TW =
    timer_w(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
  localparam int RW = $clog2(MAX_RETRIES + 1);

  localparam logic [TW-1:0] RST_LAST = TW'(RST_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(LOCK_TIMEOUT - 1);
  localparam logic [TW-1:0] STB_LAST = TW'(STABLE_CYCLES - 1);
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRIES);

  sup_state_e        state_q;
  logic [TW-1:0]     timer_q;
  logic [RW-1:0]     retry_q;
  logic [RW-1:0]     retry_d;
  logic [LOSS_W-1:0] loss_q;
  logic              pll_rst_q;
  logic              sys_rst_q;
  logic              ready_q;
  logic              fault_q;
  logic              locked_s;

  eth_sync_2ff u_lock_sync (
    .clk_i (refclk),
    .rst_i (rst),
    .d_i   (pll_locked),
    .q_o   (locked_s)
  );

  always_comb begin
    retry_d = retry_q + 1'b1;
  end

  always_ff @(posedge refclk) begin
    if (rst) begin
      state_q   <= RESET_PLL;
      timer_q   <= '0;
      retry_q   <= '0;
      loss_q    <= '0;
      pll_rst_q <= 1'b1;
      sys_rst_q <= 1'b1;
      ready_q   <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      unique case (state_q)
        RESET_PLL: begin
          if (force_relock) begin
            timer_q <= '0;
          end else if (timer_q == RST_LAST) begin
            state_q   <= WAIT_LOCK;
            timer_q   <= '0;
            pll_rst_q <= 1'b0;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        WAIT_LOCK: begin
          if (force_relock) begin
            state_q   <= RESET_PLL;
            timer_q   <= '0;
            retry_q   <= '0;
            pll_rst_q <= 1'b1;
          end else if (locked_s) begin
            state_q <= STABILIZE;
            timer_q <= '0;
          end else if (timer_q == TO_LAST) begin
            retry_q   <= retry_d;
            timer_q   <= '0;
            pll_rst_q <= 1'b1;
            if (retry_d == RETRY_MAX) begin
              state_q <= FAULT;
              fault_q <= 1'b1;
            end else begin
              state_q <= RESET_PLL;
            end
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        STABILIZE: begin
          if (force_relock) begin
            state_q   <= RESET_PLL;
            timer_q   <= '0;
            retry_q   <= '0;
            pll_rst_q <= 1'b1;
          end else if (!locked_s) begin
            state_q <= WAIT_LOCK;
            timer_q <= '0;
          end else if (timer_q == STB_LAST) begin
            state_q   <= READY;
            timer_q   <= '0;
            retry_q   <= '0;
            sys_rst_q <= 1'b0;
            ready_q   <= 1'b1;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        READY: begin
          // Loss takes priority so a coinciding force still counts it.
          if (!locked_s || force_relock) begin
            state_q   <= RESET_PLL;
            timer_q   <= '0;
            retry_q   <= '0;
            pll_rst_q <= 1'b1;
            sys_rst_q <= 1'b1;
            ready_q   <= 1'b0;
            if (!locked_s && (loss_q != '1)) begin
              loss_q <= loss_q + 1'b1;
            end
          end
        end
        FAULT: begin
          if (force_relock) begin
            state_q <= RESET_PLL;
            timer_q <= '0;
            retry_q <= '0;
            fault_q <= 1'b0;
          end
        end
        default: begin
          state_q   <= RESET_PLL;
          timer_q   <= '0;
          pll_rst_q <= 1'b1;
          sys_rst_q <= 1'b1;
          ready_q   <= 1'b0;
        end
      endcase
    end
  end

  assign pll_rst       = pll_rst_q;
  assign sys_rst       = sys_rst_q;
  assign ready         = ready_q;
  assign fault         = fault_q;
  assign lock_loss_cnt = loss_q;
  assign state_dbg     = state_q;

endmodule

// File: tb/tb_eth_pll_lock_supervisor.sv
// Directed bench for the PLL lock supervisor, small parameter set.
// Inputs change 1ns after the rising edge; outputs sampled there too.
module tb_eth_pll_lock_supervisor;

  logic       refclk = 1'b0;
  logic       rst;
  logic       pll_locked;
  logic       force_relock;
  logic       pll_rst;
  logic       sys_rst;
  logic       ready;
  logic       fault;
  logic [7:0] lock_loss_cnt;
  logic [2:0] state_dbg;

  int checks   = 0;
  int failures = 0;
  int n;

  eth_pll_lock_supervisor #(
    .RST_CYCLES    (4),
    .LOCK_TIMEOUT  (32),
    .STABLE_CYCLES (8),
    .MAX_RETRIES   (2),
    .LOSS_W        (8)
  ) dut (
    .refclk        (refclk),
    .rst           (rst),
    .pll_locked    (pll_locked),
    .force_relock  (force_relock),
    .pll_rst       (pll_rst),
    .sys_rst       (sys_rst),
    .ready         (ready),
    .fault         (fault),
    .lock_loss_cnt (lock_loss_cnt),
    .state_dbg     (state_dbg)
  );

  always #5 refclk = ~refclk;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge refclk);
    #1;
  endtask

  task automatic ticks(input int k);
    repeat (k) tick();
  endtask

  task automatic pulse_len(input string tag);
    int c;
    c = 0;
    while (pll_rst && c < 50) begin
      c++;
      tick();
    end
    chk(tag, c, 4);
  endtask

  task automatic bring_ready(input string tag);
    int c;
    pll_locked = 1'b1;
    c = 0;
    while (!ready && c < 100) begin
      tick();
      c++;
    end
    chk(tag, ready, 1);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_st"}, state_dbg, 0);
    chk({tag, "_prst"}, pll_rst, 1);
    chk({tag, "_srst"}, sys_rst, 1);
    chk({tag, "_rdy"}, ready, 0);
    chk({tag, "_flt"}, fault, 0);
    chk({tag, "_cnt"}, lock_loss_cnt, 0);
  endtask

  initial begin
    rst = 1'b1;
    pll_locked = 1'b0;
    force_relock = 1'b0;
    ticks(3);
    check_reset_vals("rst");

    // Normal bring-up
    rst = 1'b0;
    pulse_len("bring_prst_len");
    chk("bring_st_wait", state_dbg, 1);
    ticks(6);
    pll_locked = 1'b1;
    n = 0;
    while (!ready && n < 40) begin
      tick();
      n++;
    end
    chk("bring_lat_ok", (n >= 9 && n <= 11), 1);
    chk("bring_srst", sys_rst, 0);
    chk("bring_st", state_dbg, 3);
    chk("bring_cnt", lock_loss_cnt, 0);

    // Loss of lock in READY
    pll_locked = 1'b0;
    n = 0;
    while (!sys_rst && n < 10) begin
      tick();
      n++;
    end
    chk("loss_lat", n, 3);
    chk("loss_rdy", ready, 0);
    chk("loss_cnt", lock_loss_cnt, 1);
    chk("loss_st", state_dbg, 0);
    pulse_len("loss_prst_len");

    // Collision: force and lock loss seen together
    bring_ready("coll_ready");
    pll_locked = 1'b0;
    ticks(2);
    force_relock = 1'b1;
    tick();
    force_relock = 1'b0;
    chk("coll_st", state_dbg, 0);
    chk("coll_cnt", lock_loss_cnt, 2);
    pulse_len("coll_prst_len");
    chk("coll_st_wait", state_dbg, 1);

    // Force alone does not count
    bring_ready("force_ready");
    force_relock = 1'b1;
    tick();
    force_relock = 1'b0;
    chk("force_st", state_dbg, 0);
    chk("force_rdy", ready, 0);
    chk("force_cnt", lock_loss_cnt, 2);

    // Stabilize bounce
    pll_locked = 1'b0;
    n = 0;
    while (state_dbg != 3'd1 && n < 20) begin
      tick();
      n++;
    end
    chk("bnc_wait", state_dbg, 1);
    ticks(3);
    pll_locked = 1'b1;
    ticks(5);
    pll_locked = 1'b0;
    tick();
    pll_locked = 1'b1;
    ticks(2);
    chk("bnc_back_wait", state_dbg, 1);
    ticks(8);
    chk("bnc_not_ready", ready, 0);
    chk("bnc_st_stab", state_dbg, 2);
    tick();
    chk("bnc_ready", ready, 1);

    // Timeout and fault
    pll_locked = 1'b0;
    force_relock = 1'b1;
    tick();
    force_relock = 1'b0;
    chk("to_cnt_keep", lock_loss_cnt, 2);
    pulse_len("to_prst0");
    n = 0;
    while (!pll_rst && n < 100) begin
      tick();
      n++;
    end
    chk("to_wait1", n, 32);
    chk("to_st1", state_dbg, 0);
    pulse_len("to_prst1");
    n = 0;
    while (!pll_rst && n < 100) begin
      tick();
      n++;
    end
    chk("to_wait2", n, 32);
    chk("to_fault", fault, 1);
    chk("to_st_fault", state_dbg, 4);
    ticks(10);
    chk("to_prst_hold", pll_rst, 1);
    chk("to_fault_hold", fault, 1);
    force_relock = 1'b1;
    tick();
    force_relock = 1'b0;
    chk("to_clr_fault", fault, 0);
    chk("to_clr_st", state_dbg, 0);
    pulse_len("to_relock_prst");

    // Saturation of the loss counter
    for (int i = 0; i < 300; i++) begin
      bring_ready("sat_ready");
      pll_locked = 1'b0;
      n = 0;
      while (ready && n < 10) begin
        tick();
        n++;
      end
    end
    chk("sat_cnt", lock_loss_cnt, 255);

    // Mid-operation reset in STABILIZE
    pll_locked = 1'b1;
    n = 0;
    while (state_dbg != 3'd2 && n < 50) begin
      tick();
      n++;
    end
    chk("mid_stab", state_dbg, 2);
    rst = 1'b1;
    tick();
    check_reset_vals("mid_rst_stab");
    rst = 1'b0;

    // Mid-operation reset in FAULT
    pll_locked = 1'b0;
    n = 0;
    while (state_dbg != 3'd4 && n < 300) begin
      tick();
      n++;
    end
    chk("mid_fault", fault, 1);
    rst = 1'b1;
    tick();
    check_reset_vals("mid_rst_fault");
    rst = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
